// File: rtl/apb2apb_bridge_if.sv
// Host request port and memory port of the APB-to-APB bridge.
// The bridge uses the slave modport; the host/memory side uses master.
interface apb2apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_SIZE  = DATA_WIDTH / 8
);
    logic                  trnsfr;
    logic                  wr;
    logic [1:0]            dsel;
    logic [STRB_SIZE-1:0]  strb;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  slverr;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [STRB_SIZE-1:0]  mem_be;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  trnsfr, wr, dsel, strb, address, data_in, mem_data_out,
        output data_out, ready, slverr,
        output mem_wr, mem_rd, mem_be, mem_address, mem_data_in
    );

    modport master (
        output trnsfr, wr, dsel, strb, address, data_in, mem_data_out,
        input  data_out, ready, slverr,
        input  mem_wr, mem_rd, mem_be, mem_address, mem_data_in
    );
endinterface

// File: rtl/apb2apb_bridge.sv
// Host request -> internal APB master/slave -> synchronous word memory strobes.
// Latency: 3 cycles per transfer (4 with APB_WAIT_STATE_EN: one slave wait state).
// Backpressure: requests are only sampled in IDLE; inputs are ignored during SETUP/ACCESS.
module apb2apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_SIZE  = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 256
) (
    input logic              clk,
    input logic              rst,
    apb2apb_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    state_t                state;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [1:0]            pdsel;
    logic [STRB_SIZE-1:0]  pstrb;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  pready;
    logic                  xfer_ok;
    logic                  mem_hit;
    logic [DATA_WIDTH-1:0] rd_mask;

`ifdef APB_WAIT_STATE_EN
    logic wait_done;
    assign pready = psel && penable && wait_done;
`else
    assign pready = psel && penable;
`endif

    // Only the memory target exists, and it decodes words 0..MEM_DEPTH-1.
    assign xfer_ok = (pdsel == 2'b00) && (paddr < DEPTH);
    assign mem_hit = pready && xfer_ok;

    always_comb begin
        rd_mask = '0;
        for (int k = 0; k < STRB_SIZE; k++) begin
            rd_mask[k*8 +: 8] = {8{pstrb[k]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            pdsel   <= 2'b00;
            pstrb   <= '0;
            paddr   <= '0;
            pwdata  <= '0;
            rdata_q <= '0;
`ifdef APB_WAIT_STATE_EN
            wait_done <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.trnsfr) begin
                        pwrite  <= bus.wr;
                        pdsel   <= bus.dsel;
                        pstrb   <= bus.strb;
                        paddr   <= bus.address;
                        pwdata  <= bus.data_in;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        if (xfer_ok && !pwrite) begin
                            rdata_q <= bus.mem_data_out & rd_mask;
                        end
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
`ifdef APB_WAIT_STATE_EN
                        wait_done <= 1'b0;
`endif
                    end
`ifdef APB_WAIT_STATE_EN
                    else begin
                        wait_done <= 1'b1;
                    end
`endif
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out    = rdata_q;
    assign bus.ready       = pready;
    assign bus.slverr      = pready && !xfer_ok;
    assign bus.mem_wr      = mem_hit && pwrite;
    assign bus.mem_rd      = mem_hit && !pwrite;
    assign bus.mem_be      = mem_hit ? pstrb  : '0;
    assign bus.mem_address = mem_hit ? paddr  : '0;
    assign bus.mem_data_in = mem_hit ? pwdata : '0;
endmodule

// File: tb/tb_apb2apb_bridge.sv
// Directed bench for apb2apb_bridge with a 256-word byte-enabled memory model.
module tb_apb2apb_bridge;
`ifdef APB_WAIT_STATE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int PERIOD = 10;

    logic clk = 1'b0;
    logic rst;
    always #(PERIOD/2) clk = ~clk;

    apb2apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];
    assign bus.mem_data_out = bus.mem_rd ? mem[bus.mem_address[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) mem[bus.mem_address[7:0]][b*8 +: 8] <= bus.mem_data_in[b*8 +: 8];
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          r_lat, r_nstb;
    logic        r_err, r_wr, r_rd;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_din, r_prev_dout;
    time         r_t;

    // Starts in the IDLE cycle, returns at the negedge of the ready cycle.
    task automatic xfer(input logic w, input logic [1:0] ds, input logic [3:0] sb,
                        input logic [31:0] a, input logic [31:0] d, input logic hold);
        @(negedge clk);
        r_prev_dout  = bus.data_out;
        bus.trnsfr   = 1'b1;
        bus.wr       = w;
        bus.dsel     = ds;
        bus.strb     = sb;
        bus.address  = a;
        bus.data_in  = d;
        r_lat  = 0;
        r_nstb = 0;
        do begin
            @(negedge clk);
            r_lat++;
            if (!hold) bus.trnsfr = 1'b0;
            // Scramble the request mid-transfer; the latched copy must win.
            bus.wr      = ~w;
            bus.dsel    = 2'b11;
            bus.address = a ^ 32'h55;
            bus.data_in = ~d;
            bus.strb    = ~sb;
            if (bus.mem_wr || bus.mem_rd) r_nstb++;
        end while (!bus.ready && r_lat < 8);
        r_err  = bus.slverr;
        r_wr   = bus.mem_wr;
        r_rd   = bus.mem_rd;
        r_be   = bus.mem_be;
        r_addr = bus.mem_address;
        r_din  = bus.mem_data_in;
        r_t    = $time;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".data_out"}, bus.data_out, 32'h0);
        chk({tag, ".ready"}, {31'h0, bus.ready}, 32'h0);
        chk({tag, ".slverr"}, {31'h0, bus.slverr}, 32'h0);
        chk({tag, ".mem_strobes"}, {30'h0, bus.mem_wr, bus.mem_rd}, 32'h0);
        chk({tag, ".mem_address"}, bus.mem_address, 32'h0);
        chk({tag, ".mem_data_in"}, bus.mem_data_in, 32'h0);
        chk({tag, ".mem_be"}, {28'h0, bus.mem_be}, 32'h0);
    endtask

    initial begin
        time t_prev;
        int  stray;
        logic [31:0] masks [4];
        logic [31:0] held;
        masks[0] = 32'h0000004F; masks[1] = 32'h00009D00;
        masks[2] = 32'h00060000; masks[3] = 32'h1C000000;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.trnsfr = 1'b0; bus.wr = 1'b0; bus.dsel = 2'b00; bus.strb = 4'h0;
        bus.address = 32'h0; bus.data_in = 32'h0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        // Single writes 0xF0..0xF9
        for (int i = 0; i < 10; i++) begin
            xfer(1'b1, 2'b00, 4'hF, 32'hF0 + i, 32'h000A3210 + i, 1'b0);
            chk($sformatf("wr%0d.lat", i), r_lat, LAT);
            chk($sformatf("wr%0d.slverr", i), {31'h0, r_err}, 32'h0);
            chk($sformatf("wr%0d.strobes", i), {30'h0, r_wr, r_rd}, 32'h2);
            chk($sformatf("wr%0d.nstb", i), r_nstb, 1);
            chk($sformatf("wr%0d.addr", i), r_addr, 32'hF0 + i);
            chk($sformatf("wr%0d.din", i), r_din, 32'h000A3210 + i);
            chk($sformatf("wr%0d.be", i), {28'h0, r_be}, 32'hF);
        end
        chk("wr.no_data_out_change", bus.data_out, 32'h0);

        // Single reads 0xF0..0xF9
        for (int i = 0; i < 10; i++) begin
            xfer(1'b0, 2'b00, 4'hF, 32'hF0 + i, 32'h0, 1'b0);
            chk($sformatf("rd%0d.lat", i), r_lat, LAT);
            chk($sformatf("rd%0d.slverr", i), {31'h0, r_err}, 32'h0);
            chk($sformatf("rd%0d.strobes", i), {30'h0, r_wr, r_rd}, 32'h1);
            chk($sformatf("rd%0d.addr", i), r_addr, 32'hF0 + i);
            @(negedge clk);
            chk($sformatf("rd%0d.data_out", i), bus.data_out, 32'h000A3210 + i);
        end

        // Burst writes then reads with trnsfr held high
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 2'b00, 4'hF, 32'hB0 + i, 32'hC0D942F0 + i, 1'b1);
            if (i > 0) chk($sformatf("bw%0d.period", i), 32'(r_t - t_prev), (LAT + 1) * PERIOD);
            chk($sformatf("bw%0d.addr", i), r_addr, 32'hB0 + i);
            t_prev = r_t;
        end
        bus.trnsfr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 2'b00, 4'hF, 32'hB0 + i, 32'h0, 1'b1);
            if (i > 0) begin
                chk($sformatf("br%0d.period", i), 32'(r_t - t_prev), (LAT + 1) * PERIOD);
                chk($sformatf("br%0d.data", i - 1), r_prev_dout, 32'hC0D942F0 + i - 1);
            end
            t_prev = r_t;
        end
        bus.trnsfr = 1'b0;
        @(negedge clk);
        chk("br7.data", bus.data_out, 32'hC0D942F7);

        // Byte-masked reads
        xfer(1'b1, 2'b00, 4'hF, 32'h6F, 32'h1C069D4F, 1'b0);
        for (int k = 0; k < 4; k++) begin
            xfer(1'b0, 2'b00, 4'(1 << k), 32'h6F, 32'h0, 1'b0);
            @(negedge clk);
            chk($sformatf("mask%0d.data_out", k), bus.data_out, masks[k]);
        end

        // Error responses
        held = bus.data_out;
        xfer(1'b0, 2'b01, 4'hF, 32'h6F, 32'h0, 1'b0);
        chk("err_dsel.slverr", {31'h0, r_err}, 32'h1);
        chk("err_dsel.nstb", r_nstb, 0);
        @(negedge clk);
        chk("err_dsel.data_out", bus.data_out, held);
        xfer(1'b0, 2'b00, 4'hF, 32'h100, 32'h0, 1'b0);
        chk("err_addr_rd.slverr", {31'h0, r_err}, 32'h1);
        chk("err_addr_rd.nstb", r_nstb, 0);
        @(negedge clk);
        chk("err_addr_rd.data_out", bus.data_out, held);
        xfer(1'b1, 2'b00, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0);
        chk("err_addr_wr.slverr", {31'h0, r_err}, 32'h1);
        chk("err_addr_wr.nstb", r_nstb, 0);
        @(negedge clk);
        chk("err_addr_wr.mem0", mem[0], 32'h0);
        xfer(1'b0, 2'b00, 4'hF, 32'hF3, 32'h0, 1'b0);
        chk("post_err.slverr", {31'h0, r_err}, 32'h0);

        // Reset during SETUP
        @(negedge clk);
        bus.trnsfr = 1'b1; bus.wr = 1'b1; bus.dsel = 2'b00; bus.strb = 4'hF;
        bus.address = 32'h50; bus.data_in = 32'h12345678;
        @(negedge clk);
        bus.trnsfr = 1'b0;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_setup");
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_wr || bus.mem_rd || bus.ready) stray++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_wr || bus.mem_rd || bus.ready) stray++;
        end
        chk("rst_setup.stray", stray, 0);
        chk("rst_setup.mem50", mem[8'h50], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
